sensor_conditioner: RTL and testbench

- Sits directly downstream of the two-channel SPI ADC front end. Consumes its free-running 12-bit dial (ch0) and CdS light (ch1) values.
- Snapshots both channels at a fixed sample rate and applies a power-of-two moving average per channel.
- Derives a hysteretic 16-step dial level and a hysteretic dark flag for the Phase 2 and Event 1 logic.
- Emits one-cycle strobes on every new result and on every level/dark change.

---
 rtl/sensor_pkg.sv | 25 ++
 rtl/sensor_conditioner_if.sv | 27 ++
 rtl/sensor_moving_avg.sv | 45 ++++
 rtl/sensor_conditioner.sv | 140 ++++++++++++++
 tb/tb_sensor_conditioner.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sensor_pkg.sv
// Shared widths, FSM encoding and default thresholds for the sensor conditioner.
package sensor_pkg;

  localparam int ADC_W   = 12;
  localparam int LEVEL_W = 4;

  localparam int DEF_SAMPLE_DIV  = 50000;
  localparam int DEF_AVG_LOG2    = 3;
  localparam int DEF_DIAL_HYST   = 32;
  localparam int DEF_DARK_ON_TH  = 800;
  localparam int DEF_DARK_OFF_TH = 1200;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    UPDATE   = 2'd2,
    CLASSIFY = 2'd3
  } state_t;

  function automatic logic [ADC_W-1:0] abs_diff(input logic [ADC_W-1:0] a,
                                                input logic [ADC_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Raw ADC inputs and conditioned results; master = conditioner, slave = consumer/front end.
interface sensor_conditioner_if;
  import sensor_pkg::*;

  logic [ADC_W-1:0]   dial_value;
  logic [ADC_W-1:0]   cds_value;
  logic [ADC_W-1:0]   dial_filt;
  logic [ADC_W-1:0]   cds_filt;
  logic [LEVEL_W-1:0] dial_level;
  logic               dark;
  logic               sample_valid;
  logic               level_changed;
  logic               dark_rise;

  modport master (
    input  dial_value, cds_value,
    output dial_filt, cds_filt, dial_level, dark,
           sample_valid, level_changed, dark_rise
  );

  modport slave (
    output dial_value, cds_value,
    input  dial_filt, cds_filt, dial_level, dark,
           sample_valid, level_changed, dark_rise
  );

endinterface

// File: rtl/sensor_moving_avg.sv
// Power-of-two moving average; the first load after reset fills every tap with the sample.
module sensor_moving_avg
  import sensor_pkg::*;
#(
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ADC_W-1:0] sample,
  output logic [ADC_W-1:0] filt
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = ADC_W + AVG_LOG2;

  logic [ADC_W-1:0]    taps [DEPTH];
  logic [SUM_W-1:0]    sum;
  logic [AVG_LOG2-1:0] ptr;
  logic                primed;

  // NOTE: the tap array is reset explicitly because the first average after reset
  // must start from a known buffer; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum    <= '0;
      ptr    <= '0;
      primed <= 1'b0;
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (load) begin
      if (!primed) begin
        for (int i = 0; i < DEPTH; i++) taps[i] <= sample;
        sum    <= SUM_W'(sample) << AVG_LOG2;
        primed <= 1'b1;
      end else begin
        sum       <= sum - SUM_W'(taps[ptr]) + SUM_W'(sample);
        taps[ptr] <= sample;
        ptr       <= ptr + 1'b1;
      end
    end
  end

  assign filt = ADC_W'(sum >> AVG_LOG2);

endmodule

// File: rtl/sensor_conditioner.sv
// Sample-rate snapshot, moving average and hysteretic dial level / dark flag.
// Define SENSOR_CONDITIONER_BYPASS_EN to remove the averaging path (filt = snapshot).
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int AVG_LOG2    = DEF_AVG_LOG2,
  parameter int DIAL_HYST   = DEF_DIAL_HYST,
  parameter int DARK_ON_TH  = DEF_DARK_ON_TH,
  parameter int DARK_OFF_TH = DEF_DARK_OFF_TH
) (
  input logic                  clk,
  input logic                  rst,
  sensor_conditioner_if.master bus
);

  localparam int                CNT_W    = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [ADC_W-1:0]  HYST_TH  = ADC_W'(128 + DIAL_HYST);
  localparam logic [ADC_W-1:0]  ON_TH    = ADC_W'(DARK_ON_TH);
  localparam logic [ADC_W-1:0]  OFF_TH   = ADC_W'(DARK_OFF_TH);

  state_t             state, state_next;
  logic [CNT_W-1:0]   div_cnt;
  logic               tick;
  logic               capture, classify;
  logic [ADC_W-1:0]   snap_d, snap_c;
  logic [ADC_W-1:0]   dial_f, cds_f;
  logic [ADC_W-1:0]   dial_filt_q, cds_filt_q;
  logic [LEVEL_W-1:0] dial_level_q, cand;
  logic [ADC_W-1:0]   center;
  logic               level_move;
  logic               dark_q, primed;
  logic               sample_valid_q, level_changed_q, dark_rise_q;

  assign tick = (div_cnt == CNT_LAST);

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      state   <= IDLE;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      state   <= state_next;
    end
  end

  // NOTE: outputs and next state take their defaults first so no path leaves them
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    classify   = 1'b0;
    unique case (state)
      IDLE:     if (tick) state_next = CAPTURE;
      CAPTURE:  begin capture = 1'b1;  state_next = UPDATE; end
      UPDATE:   state_next = CLASSIFY;
      CLASSIFY: begin classify = 1'b1; state_next = IDLE; end
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_d <= '0;
      snap_c <= '0;
    end else if (capture) begin
      snap_d <= bus.dial_value;
      snap_c <= bus.cds_value;
    end
  end

`ifdef SENSOR_CONDITIONER_BYPASS_EN
  assign dial_f = snap_d;
  assign cds_f  = snap_c;
`else
  logic load;
  assign load = (state == UPDATE);

  sensor_moving_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_dial (
    .clk(clk), .rst(rst), .load(load), .sample(snap_d), .filt(dial_f)
  );

  sensor_moving_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_cds (
    .clk(clk), .rst(rst), .load(load), .sample(snap_c), .filt(cds_f)
  );
`endif

  // Move only when the new value sits clearly outside the current bin plus margin.
  assign cand       = dial_f[ADC_W-1 -: LEVEL_W];
  assign center     = {dial_level_q, 1'b1, 7'b0};
  assign level_move = (cand != dial_level_q) && (abs_diff(dial_f, center) > HYST_TH);

  always_ff @(posedge clk) begin
    if (rst) begin
      dial_filt_q     <= '0;
      cds_filt_q      <= '0;
      dial_level_q    <= '0;
      dark_q          <= 1'b0;
      primed          <= 1'b0;
      sample_valid_q  <= 1'b0;
      level_changed_q <= 1'b0;
      dark_rise_q     <= 1'b0;
    end else begin
      sample_valid_q  <= 1'b0;
      level_changed_q <= 1'b0;
      dark_rise_q     <= 1'b0;
      if (classify) begin
        dial_filt_q    <= dial_f;
        cds_filt_q     <= cds_f;
        sample_valid_q <= 1'b1;
        if (!primed) begin
          dial_level_q    <= cand;
          level_changed_q <= (cand != '0);
          primed          <= 1'b1;
        end else if (level_move) begin
          dial_level_q    <= cand;
          level_changed_q <= 1'b1;
        end
        if (!dark_q && cds_f <= ON_TH) begin
          dark_q      <= 1'b1;
          dark_rise_q <= 1'b1;
        end else if (dark_q && cds_f >= OFF_TH) begin
          dark_q <= 1'b0;
        end
      end
    end
  end

  assign bus.dial_filt     = dial_filt_q;
  assign bus.cds_filt      = cds_filt_q;
  assign bus.dial_level    = dial_level_q;
  assign bus.dark          = dark_q;
  assign bus.sample_valid  = sample_valid_q;
  assign bus.level_changed = level_changed_q;
  assign bus.dark_rise     = dark_rise_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner: reset, latency, averaging, hysteresis, mid-sample reset.
module tb_sensor_conditioner;
  import sensor_pkg::*;

  localparam int DIV = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sensor_conditioner_if bus ();

  sensor_conditioner #(.SAMPLE_DIV(DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int stray = 0;

  typedef struct {
    logic [11:0] dial;
    logic [11:0] cds;
    int          nsamp;
    logic [11:0] e_dfilt;
    logic [3:0]  e_level;
    logic [11:0] e_cfilt;
    logic        e_dark;
    int          e_lvl_pulses;
    int          e_rise_pulses;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Waits for the next sample_valid pulse; cycles counts edges since the call.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (cycles < 4 * DIV) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.sample_valid === 1'b1) break;
      if (bus.level_changed === 1'b1 || bus.dark_rise === 1'b1) stray++;
    end
    check("valid_seen", {31'd0, bus.sample_valid}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dial_filt"}, {20'd0, bus.dial_filt}, 32'd0);
    check({tag, "_cds_filt"},  {20'd0, bus.cds_filt},  32'd0);
    check({tag, "_level"},     {28'd0, bus.dial_level}, 32'd0);
    check({tag, "_dark"},      {31'd0, bus.dark}, 32'd0);
    check({tag, "_valid"},     {31'd0, bus.sample_valid}, 32'd0);
    check({tag, "_lvl_chg"},   {31'd0, bus.level_changed}, 32'd0);
    check({tag, "_dark_rise"}, {31'd0, bus.dark_rise}, 32'd0);
  endtask

  task automatic do_reset(input logic [11:0] dial, input logic [11:0] cds);
    bus.dial_value = dial;
    bus.cds_value  = cds;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int lp;
    int rp;
    logic [11:0] exp_f;

    // Dial level 5 is the starting point; rows then exercise hysteresis and dark.
    vecs[0] = '{12'd1568, 12'd3000, 8, 12'd1568, 4'd5, 12'd3000, 1'b0, 0, 0};
    vecs[1] = '{12'd1569, 12'd3000, 8, 12'd1569, 4'd6, 12'd3000, 1'b0, 1, 0};
    vecs[2] = '{12'd1510, 12'd3000, 8, 12'd1510, 4'd6, 12'd3000, 1'b0, 0, 0};
    vecs[3] = '{12'd1510, 12'd1000, 8, 12'd1510, 4'd6, 12'd1000, 1'b0, 0, 0};
    vecs[4] = '{12'd1510, 12'd800,  8, 12'd1510, 4'd6, 12'd800,  1'b1, 0, 1};
    vecs[5] = '{12'd1510, 12'd1000, 8, 12'd1510, 4'd6, 12'd1000, 1'b1, 0, 0};
    vecs[6] = '{12'd1510, 12'd1199, 8, 12'd1510, 4'd6, 12'd1199, 1'b1, 0, 0};
    vecs[7] = '{12'd1510, 12'd1200, 8, 12'd1510, 4'd6, 12'd1200, 1'b0, 0, 0};
    vecs[8] = '{12'd1510, 12'd700,  8, 12'd1510, 4'd6, 12'd700,  1'b1, 0, 1};

    // Reset state and first-sample latency.
    bus.dial_value = 12'h555;
    bus.cds_value  = 12'd3000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    wait_valid(cyc);
    check("first_latency", cyc, 32'd19);
    check("first_dial_filt", {20'd0, bus.dial_filt}, 32'h555);
    check("first_level", {28'd0, bus.dial_level}, 32'd5);
    check("first_lvl_chg", {31'd0, bus.level_changed}, 32'd1);
    check("first_cds_filt", {20'd0, bus.cds_filt}, 32'd3000);
    check("first_dark", {31'd0, bus.dark}, 32'd0);
    check("first_dark_rise", {31'd0, bus.dark_rise}, 32'd0);
    @(posedge clk);
    #1;
    check("valid_one_cycle", {31'd0, bus.sample_valid}, 32'd0);
    check("lvl_chg_one_cycle", {31'd0, bus.level_changed}, 32'd0);
    wait_valid(cyc);
    check("sample_period", cyc, DIV - 1);
    check("steady_lvl_chg", {31'd0, bus.level_changed}, 32'd0);

    // Averaging step response after priming at zero.
    do_reset(12'h000, 12'd3000);
    wait_valid(cyc);
    check("prime_zero_filt", {20'd0, bus.dial_filt}, 32'd0);
    check("prime_zero_level", {28'd0, bus.dial_level}, 32'd0);
    check("prime_zero_lvl_chg", {31'd0, bus.level_changed}, 32'd0);
    bus.dial_value = 12'h800;
    for (int k = 1; k <= 9; k++) begin
      wait_valid(cyc);
`ifdef SENSOR_CONDITIONER_BYPASS_EN
      exp_f = 12'h800;
`else
      exp_f = (k >= 8) ? 12'h800 : 12'(k * 256);
`endif
      check($sformatf("avg_step_%0d", k), {20'd0, bus.dial_filt}, {20'd0, exp_f});
    end

    // Table: hysteresis of dial level and dark flag, each row held for nsamp samples.
    do_reset(12'h555, 12'd3000);
    wait_valid(cyc);
    check("table_start_level", {28'd0, bus.dial_level}, 32'd5);
    for (int v = 0; v < 9; v++) begin
      bus.dial_value = vecs[v].dial;
      bus.cds_value  = vecs[v].cds;
      lp = 0;
      rp = 0;
      for (int s = 0; s < vecs[v].nsamp; s++) begin
        wait_valid(cyc);
        lp += int'(bus.level_changed);
        rp += int'(bus.dark_rise);
      end
      check($sformatf("vec%0d_dial_filt", v), {20'd0, bus.dial_filt}, {20'd0, vecs[v].e_dfilt});
      check($sformatf("vec%0d_level", v), {28'd0, bus.dial_level}, {28'd0, vecs[v].e_level});
      check($sformatf("vec%0d_cds_filt", v), {20'd0, bus.cds_filt}, {20'd0, vecs[v].e_cfilt});
      check($sformatf("vec%0d_dark", v), {31'd0, bus.dark}, {31'd0, vecs[v].e_dark});
      check($sformatf("vec%0d_lvl_pulses", v), lp, vecs[v].e_lvl_pulses);
      check($sformatf("vec%0d_rise_pulses", v), rp, vecs[v].e_rise_pulses);
    end

    // Reset during UPDATE: valid was just seen, next tick is 12 cycles later.
    bus.dial_value = 12'h200;
    bus.cds_value  = 12'd900;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    rst = 1'b0;
    wait_valid(cyc);
    check("reprime_latency", cyc, 32'd19);
    check("reprime_dial_filt", {20'd0, bus.dial_filt}, 32'h200);
    check("reprime_level", {28'd0, bus.dial_level}, 32'd2);
    check("reprime_lvl_chg", {31'd0, bus.level_changed}, 32'd1);
    check("reprime_cds_filt", {20'd0, bus.cds_filt}, 32'd900);
    check("reprime_dark", {31'd0, bus.dark}, 32'd0);

    check("stray_pulses", stray, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
